// File: rtl/axil_byte_serializer.sv
// rtl/axil_byte_serializer.sv - splits a strobed write word into Wishbone classic byte writes
// Bytes go out lowest strobe first; completion reports acked byte count and timeout/count errors.
module axil_byte_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 255,
  localparam int NB = DATA_WIDTH / 8,
  localparam int CW = $clog2(NB) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [NB-1:0]         in_strb,
  input  logic [CW-1:0]         in_ones,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [7:0]            wb_dat_o,
  input  logic                  wb_ack_i,
  output logic                  done_o,
  output logic [CW-1:0]         done_bytes_o,
  output logic                  err_o
);

  localparam int KW = $clog2(NB);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [NB-1:0]         mask;
  logic [CW-1:0]         remaining;
  logic [CW-1:0]         done_bytes;
  logic                  err;
  logic [TW-1:0]         tcnt;

  logic                  hs;
  logic                  ack;
  logic [KW-1:0]         k;
  logic [NB-1:0]         mask_nxt;
  logic [CW-1:0]         rem_nxt;
  logic                  last_ack;
  logic                  tmo;

  assign hs  = in_valid && (state == IDLE);
  assign ack = (state == ISSUE) && wb_ack_i;

  // Lowest pending strobe; scanning downward lets the lowest index win.
  always_comb begin
    k = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (mask[i]) k = i[KW-1:0];
    end
  end

  assign mask_nxt = mask & ~(NB'(1) << k);
  assign rem_nxt  = remaining - CW'(1);
  assign last_ack = ack && ((mask_nxt == '0) || (rem_nxt == '0));
  assign tmo      = (state == ISSUE) && !wb_ack_i && (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = ((in_ones == '0) || (in_strb == '0)) ? DONE : ISSUE;
      ISSUE:   if (last_ack || tmo) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      data_q     <= '0;
      mask       <= '0;
      remaining  <= '0;
      done_bytes <= '0;
      err        <= 1'b0;
      tcnt       <= '0;
    end else if (hs) begin
      addr_q     <= in_addr;
      data_q     <= in_data;
      mask       <= in_strb;
      remaining  <= in_ones;
      done_bytes <= '0;
      tcnt       <= '0;
      // A word skipped outright still reports a strobe/count disagreement.
      err        <= (in_ones == '0) != (in_strb == '0);
    end else if (state == ISSUE) begin
      if (wb_ack_i) begin
        mask       <= mask_nxt;
        remaining  <= rem_nxt;
        done_bytes <= done_bytes + CW'(1);
        tcnt       <= '0;
        if (last_ack) err <= (mask_nxt == '0) != (rem_nxt == '0);
      end else if (tmo) begin
        err <= 1'b1;
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

  always_comb begin
    in_ready     = (state == IDLE);
    wb_cyc_o     = (state == ISSUE);
    wb_stb_o     = (state == ISSUE);
    wb_we_o      = (state == ISSUE);
    wb_adr_o     = '0;
    wb_dat_o     = '0;
    done_o       = (state == DONE);
    done_bytes_o = done_bytes;
    err_o        = err;
    if (state == ISSUE) begin
      wb_adr_o = {addr_q[ADDR_WIDTH-1:KW], k};
      wb_dat_o = data_q[{k, 3'b000} +: 8];
    end
  end

endmodule
